// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared FSM state type and sizing helper for the ADC command sequencer
package adc_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adc_seq_timeout.sv
// adc_seq_timeout: response watchdog; cleared on command accept, counts while enabled
module adc_seq_timeout import adc_seq_pkg::*; #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = slot_w(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i ? cnt_q + 1'b1 : cnt_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/adc_cmd_sequencer.sv
// adc_cmd_sequencer: round-robin Avalon-ST command source and response sink for the modular ADC
module adc_cmd_sequencer import adc_seq_pkg::*; #(
  parameter int NUM_CH      = 4,
  parameter int FIRST_CH    = 1,
  parameter int CH_W        = 5,
  parameter int DATA_W      = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  input  logic                       run,
  input  logic                       single,
  input  logic                       err_clr,
  output logic                       cmd_valid,
  output logic [CH_W-1:0]            cmd_channel,
  output logic                       cmd_sop,
  output logic                       cmd_eop,
  input  logic                       cmd_ready,
  input  logic                       rsp_valid,
  input  logic [CH_W-1:0]            rsp_channel,
  input  logic [DATA_W-1:0]          rsp_data,
  output logic                       sample_valid,
  output logic [slot_w(NUM_CH)-1:0]  sample_slot,
  output logic [DATA_W-1:0]          sample_data,
  output logic [NUM_CH*DATA_W-1:0]   results,
  output logic                       sweep_done,
  output logic                       busy,
  output logic                       err_mismatch,
  output logic                       err_timeout
);
  localparam int SW = slot_w(NUM_CH);
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);
  state_e state_q, state_d;
  logic [SW-1:0] slot_q, slot_d, sample_slot_q, sample_slot_d;
  logic [DATA_W-1:0] sample_data_q, sample_data_d;
  logic [NUM_CH*DATA_W-1:0] results_q, results_d;
  logic sample_valid_q, sample_valid_d, sweep_done_q, sweep_done_d;
  logic mm_q, mm_d, to_q, to_d;
  logic accept, take, expired, step;
  logic [CH_W-1:0] exp_ch;
  assign exp_ch = CH_W'(FIRST_CH + int'(slot_q));
  assign accept = (state_q == ISSUE) && cmd_ready;
  assign take = (state_q == WAIT) && rsp_valid;
  assign step = take || expired;
  adc_seq_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk(clk_clk),
    .rst(reset_reset),
    .clr_i(accept),
    .en_i(state_q == WAIT),
    .expired_o(expired)
  );
  // A response arriving on the expiry cycle counts as a response, not a timeout
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    results_d = results_q;
    sample_valid_d = take;
    sample_slot_d = take ? slot_q : sample_slot_q;
    sample_data_d = take ? rsp_data : sample_data_q;
    sweep_done_d = step && (slot_q == LAST);
    mm_d = (take && rsp_channel != exp_ch) || (mm_q && !err_clr);
    to_d = (expired && !rsp_valid) || (to_q && !err_clr);
    if (take) results_d[int'(slot_q)*DATA_W +: DATA_W] = rsp_data;
    if (state_q == IDLE && (run || single)) state_d = ISSUE;
    if (accept) state_d = WAIT;
    if (step) begin
      slot_d = (slot_q == LAST) ? '0 : slot_q + 1'b1;
      state_d = (slot_q != LAST || run) ? ISSUE : IDLE;
    end
  end
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      state_q <= IDLE;
      slot_q <= '0;
      results_q <= '0;
      sample_valid_q <= 1'b0;
      sample_slot_q <= '0;
      sample_data_q <= '0;
      sweep_done_q <= 1'b0;
      mm_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      results_q <= results_d;
      sample_valid_q <= sample_valid_d;
      sample_slot_q <= sample_slot_d;
      sample_data_q <= sample_data_d;
      sweep_done_q <= sweep_done_d;
      mm_q <= mm_d;
      to_q <= to_d;
    end
  assign cmd_valid = (state_q == ISSUE);
  assign cmd_sop = cmd_valid;
  assign cmd_eop = cmd_valid;
  assign cmd_channel = cmd_valid ? exp_ch : '0;
  assign busy = (state_q != IDLE);
  assign sample_valid = sample_valid_q;
  assign sample_slot = sample_slot_q;
  assign sample_data = sample_data_q;
  assign results = results_q;
  assign sweep_done = sweep_done_q;
  assign err_mismatch = mm_q;
  assign err_timeout = to_q;
endmodule
